// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//
// Shared definitions for the datapath logic units.
//   - OP_AND / OP_OR / OP_XOR / OP_NOR : 2-bit bitwise operation codes
//   - state_t                          : control FSM states of the
//                                        digit-serial logic engine
// ---------------------------------------------------------------------------
package alu_pkg;

  // Bitwise operation codes, shared with the single-cycle ALU gates.
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  // Control states of the serial engine. The fourth encoding (2'b11) is
  // unused and is steered back to IDLE by the next-state logic.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage : alu_pkg

// File: rtl/logic_slice.sv
// ---------------------------------------------------------------------------
// logic_slice
//
// Purely combinational DIGIT-bit bitwise slice. Every bit position has its
// own AND/OR/XOR/NOR gate, and op picks which gate bank drives z.
//
// Ports
//   op  in   2      operation code (see alu_pkg)
//   x   in   DIGIT  first operand digit
//   y   in   DIGIT  second operand digit
//   z   out  DIGIT  x <op> y
// ---------------------------------------------------------------------------
module logic_slice
  import alu_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [1:0]       op,
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic [DIGIT-1:0] z
);

  logic [DIGIT-1:0] and_w;
  logic [DIGIT-1:0] or_w;
  logic [DIGIT-1:0] xor_w;
  logic [DIGIT-1:0] nor_w;

  // One gate of each kind per bit position. All four banks are always
  // evaluating; the select below only chooses which one reaches z.
  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    and u_and (and_w[i], x[i], y[i]);
    or  u_or  (or_w[i],  x[i], y[i]);
    xor u_xor (xor_w[i], x[i], y[i]);
    nor u_nor (nor_w[i], x[i], y[i]);
  end

  // Operation select. The default arm covers OP_NOR, so every 2-bit code
  // maps to a defined gate bank.
  always_comb begin
    z = nor_w;
    case (op)
      OP_AND:  z = and_w;
      OP_OR:   z = or_w;
      OP_XOR:  z = xor_w;
      default: z = nor_w;
    endcase
  end

endmodule : logic_slice

// File: rtl/serial_logic_unit.sv
// ---------------------------------------------------------------------------
// serial_logic_unit
//
// Digit-serial bitwise logic engine. A request carrying two WIDTH-bit
// operands and an opcode is accepted over a valid/ready handshake. The unit
// then processes DIGIT bits per clock, LSB digit first, over N = WIDTH/DIGIT
// RUN cycles. It returns the result and a zero flag over a second
// valid/ready handshake. This is the small sequential counterpart of the
// single-cycle bitwise gates in the ALU.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      request valid
//   in_ready   out  1      unit idle and able to accept a request
//   op         in   2      00 AND, 01 OR, 10 XOR, 11 NOR
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   out_valid  out  1      result valid (DONE state)
//   out_ready  in   1      consumer accepts the result
//   result     out  WIDTH  a <op> b
//   zero       out  1      result == 0
// ---------------------------------------------------------------------------
module serial_logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // A width that does not split into whole digits would leave a partial
  // digit at the top, so it is rejected during elaboration.
  if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_param_check
    $error("serial_logic_unit: WIDTH (%0d) must be a multiple of DIGIT (%0d)",
           WIDTH, DIGIT);
  end

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             zero_q;
  logic [DIGIT-1:0] slice_z;
  logic [WIDTH-1:0] res_shifted;
  logic             accept;
  logic             last_digit;

  // Handshake outputs are decoded from the state alone. The only exception
  // is that in_ready is also forced low while reset is asserted.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign result    = res_sr;
  assign zero      = zero_q;

  assign accept     = in_valid && in_ready;
  assign last_digit = (count == LAST);

  // The current low digit of each operand goes through the gate slice.
  logic_slice #(
    .DIGIT (DIGIT)
  ) u_slice (
    .op (op_q),
    .x  (a_sr[DIGIT-1:0]),
    .y  (b_sr[DIGIT-1:0]),
    .z  (slice_z)
  );

  // The result register fills from the top. New digits are shifted in at
  // the MSB end and older digits move right. After N shifts the first
  // (least significant) digit lands at bit 0. Concatenate-then-shift keeps
  // this valid even when a single digit spans the whole width.
  assign res_shifted = WIDTH'({slice_z, res_sr} >> DIGIT);

  // Next-state logic. A request is taken only from IDLE. RUN lasts exactly
  // N cycles. DONE waits indefinitely for the consumer. The unused
  // encoding falls back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)     state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // State and datapath registers. Reset wins over everything, so an
  // in-flight operation is simply dropped. On accept, the operands and
  // opcode are snapshotted, which makes later input changes irrelevant.
  // During RUN, the operands and the result all shift by one digit per
  // cycle. The zero flag is captured together with the final result digit,
  // so it always describes the value on the result port in DONE. The
  // counter stops at N-1 and never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      op_q   <= OP_AND;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      zero_q <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            op_q  <= op;
            count <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_shifted;
          if (last_digit) begin
            zero_q <= (res_shifted == '0);
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : serial_logic_unit

// File: tb/tb_serial_logic_unit.sv
// ---------------------------------------------------------------------------
// tb_serial_logic_unit
//
// Directed testbench for serial_logic_unit with the default WIDTH=32 and
// DIGIT=4. Inputs are driven and outputs are sampled 1 time unit after
// each rising clock edge.
// ---------------------------------------------------------------------------
module tb_serial_logic_unit;

  localparam int WIDTH = 32;
  localparam int N     = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  int tests_run;
  int tests_failed;
  int cyc;

  serial_logic_unit #(
    .WIDTH (WIDTH),
    .DIGIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 unit before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Count one comparison and report it if it does not match.
  task automatic check_output(input string tag, input logic [WIDTH-1:0] obs,
                              input logic [WIDTH-1:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of the bitwise operations.
  function automatic logic [WIDTH-1:0] model(input logic [1:0] o,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  // Present one request and wait for the result. Checks latency, result
  // and zero flag. Returns with the unit still in DONE.
  task automatic apply_stimulus(input string tag, input logic [1:0] o,
                                input logic [WIDTH-1:0] x,
                                input logic [WIDTH-1:0] y,
                                input logic [WIDTH-1:0] exp_res,
                                input logic exp_zero);
    int edges;
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    check_output({tag, " in_ready"}, WIDTH'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    a        = ~x;
    b        = ~y;
    edges    = 0;
    while (!out_valid && edges < 20) begin
      tick();
      edges++;
    end
    check_output({tag, " latency"}, WIDTH'(edges), WIDTH'(N));
    check_output({tag, " result"}, result, exp_res);
    check_output({tag, " zero"}, WIDTH'(zero), WIDTH'(exp_zero));
  endtask

  initial begin
    int   seen;
    int   w;
    int   acc [4];
    logic [1:0]       b2b_op [4];
    logic [WIDTH-1:0] b2b_a  [4];
    logic [WIDTH-1:0] b2b_b  [4];

    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    op           = 2'b00;
    a            = '0;
    b            = '0;

    // Reset state.
    tick();
    tick();
    check_output("reset out_valid", WIDTH'(out_valid), 32'd0);
    check_output("reset result", result, 32'h0);
    check_output("reset zero", WIDTH'(zero), 32'd0);
    check_output("reset in_ready", WIDTH'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_output("post-reset in_ready", WIDTH'(in_ready), 32'd1);

    // AND, OR, NOR with immediate result acceptance.
    apply_stimulus("and", 2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0);
    tick();
    check_output("and release out_valid", WIDTH'(out_valid), 32'd0);
    check_output("and idle result held", result, 32'h0F0F_0000);
    apply_stimulus("or", 2'b01, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hFFFF_0F0F, 1'b0);
    tick();
    apply_stimulus("nor", 2'b11, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0000_F0F0, 1'b0);
    tick();
    apply_stimulus("nor zeros", 2'b11, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    tick();

    // XOR of equal operands gives zero.
    apply_stimulus("xor eq", 2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 1'b1);
    tick();

    // Backpressure: hold the result for 5 cycles, ignoring a request pulse.
    out_ready = 1'b0;
    apply_stimulus("bp", 2'b10, 32'hA5A5_A5A5, 32'h0F0F_F0F0, 32'hAAAA_5555, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        in_valid = 1'b1;
        a        = 32'h1111_1111;
        b        = 32'h2222_2222;
        op       = 2'b01;
      end
      tick();
      in_valid = 1'b0;
      check_output("bp out_valid", WIDTH'(out_valid), 32'd1);
      check_output("bp result", result, 32'hAAAA_5555);
      check_output("bp in_ready", WIDTH'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check_output("bp release out_valid", WIDTH'(out_valid), 32'd0);
    check_output("bp release in_ready", WIDTH'(in_ready), 32'd1);
    seen = 0;
    repeat (10) begin
      tick();
      if (out_valid) seen = 1;
    end
    check_output("bp ignored pulse", WIDTH'(seen), 32'd0);

    // Reset in the middle of an operation.
    op       = 2'b01;
    a        = 32'hCAFE_0000;
    b        = 32'h0000_BABE;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_output("midrst out_valid", WIDTH'(out_valid), 32'd0);
    check_output("midrst in_ready", WIDTH'(in_ready), 32'd0);
    check_output("midrst result", result, 32'h0);
    rst = 1'b0;
    #1;
    check_output("midrst in_ready after", WIDTH'(in_ready), 32'd1);
    seen = 0;
    repeat (12) begin
      tick();
      if (out_valid) seen = 1;
    end
    check_output("midrst no output", WIDTH'(seen), 32'd0);
    apply_stimulus("after rst and", 2'b00, 32'h1234_5678, 32'hFFFF_FFFF,
                   32'h1234_5678, 1'b0);
    tick();

    // Back-to-back with in_valid held high.
    b2b_op[0] = 2'b01; b2b_a[0] = 32'h1234_0000; b2b_b[0] = 32'h0000_ABCD;
    b2b_op[1] = 2'b11; b2b_a[1] = 32'hFFFF_0000; b2b_b[1] = 32'h00FF_00FF;
    b2b_op[2] = 2'b10; b2b_a[2] = 32'h8001_7FFE; b2b_b[2] = 32'hFFFF_FFFF;
    b2b_op[3] = 2'b00; b2b_a[3] = 32'hF0F0_3C3C; b2b_b[3] = 32'h0FF0_FF00;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op = b2b_op[i];
      a  = b2b_a[i];
      b  = b2b_b[i];
      w  = 0;
      while (!in_ready && w < 20) begin
        tick();
        w++;
      end
      tick();
      acc[i] = cyc;
      w = 0;
      while (!out_valid && w < 20) begin
        tick();
        w++;
      end
      check_output("b2b out_valid", WIDTH'(out_valid), 32'd1);
      check_output("b2b result", result, model(b2b_op[i], b2b_a[i], b2b_b[i]));
      if (i > 0) begin
        check_output("b2b spacing", WIDTH'(acc[i] - acc[i-1]), 32'd10);
      end
      tick();
    end
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_serial_logic_unit
